i2c_slave_mem: RTL and testbench
================================

Name: i2c_slave_mem

Overview:
- Synthesizable I2C slave with a byte-addressed register memory, sitting directly downstream of the iicmb controller on one I2C bus (scl/sda).
- Serves as an RTL target for iicmb write, read and repeated-start traffic; can stand in for the behavioural i2c slave BFM.
- Oversamples SCL/SDA on the system clock and drives both lines open-drain.
- Implements EEPROM-style pointer addressing.

Parameters:
- SLAVE_ADDR, 7'h22, 7-bit I2C address this slave responds to.
- MEM_DEPTH, 64, number of bytes in memory; must be a power of two, at most 256.
- SYNC_STAGES, 2, number of synchronizer flops on scl_i and sda_i.

Ports:
- clk_i  in  1  system clock.
- rst_n_i  in  1  asynchronous active-low reset.
- scl_i  in  1  I2C clock line as sampled from the bus.
- sda_i  in  1  I2C data line as sampled from the bus.
- scl_o  out  1  open-drain SCL drive; 0 pulls low, 1 releases.
- sda_o  out  1  open-drain SDA drive; 0 pulls low, 1 releases.
- busy_o  out  1  high from an address-matched START until STOP.
- wr_stb_o  out  1  one-cycle pulse when a data byte is committed to memory.
- wr_addr_o  out  $clog2(MEM_DEPTH)  memory address of the committed byte.
- wr_data_o  out  8  committed data byte.

Behaviour:
- Clock and reset: single clock domain, clk_i. Reset rst_n_i is asynchronous, active-low.
- Reset values:
  - scl_o=1, sda_o=1, busy_o=0, wr_stb_o=0, wr_addr_o=0, wr_data_o=0.
  - Pointer = 0, state = IDLE.
  - Memory byte i = i[7:0].
- Synchronization and events:
  - scl_i and sda_i pass through SYNC_STAGES flops; edges are taken from the last two synchronized samples.
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - Data bits are sampled on the SCL rising edge.
  - sda_o changes only on a detected SCL falling edge, giving SYNC_STAGES+1 clocks of hold.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK.
  - IDLE: wait for START, then go to ADDR.
  - ADDR: shift 8 bits, MSB first.
    - If bits [7:1] == SLAVE_ADDR, drive ACK (sda_o=0) for the 9th clock.
    - Otherwise release SDA and return to IDLE until the next START.
  - After ADDR_ACK, R/W=0 goes to PTR.
  - After ADDR_ACK, R/W=1 goes to RD_DATA, with the byte at the pointer loaded before the first SCL falling edge.
  - PTR: the first byte after a write address loads the pointer, masked to log2(MEM_DEPTH) bits. ACK it, then go to WR_DATA.
  - WR_DATA: shift 8 bits and ACK them.
    - wr_stb_o pulses on the SCL falling edge that ends the ACK bit; wr_addr_o/wr_data_o are held until the next commit.
    - Memory is written and the pointer incremented, wrapping from MEM_DEPTH-1 to 0.
  - RD_DATA: drive bits MSB first, release SDA for the 9th bit, then sample the master's ACK/NACK in RD_ACK.
    - ACK (0): increment the pointer with wrap and load the next byte.
    - NACK (1): release SDA and go to IDLE; the pointer is still incremented.
- Boundary conditions:
  - START in any state, including mid-byte (repeated START): abort the current byte, keep the pointer, go to ADDR. An uncommitted partial write byte is discarded.
  - STOP in any state: release SDA and go to IDLE; busy_o deasserts the next clock.
  - Read followed by NACK then STOP: no further SDA drive.
  - General call address 7'h00 is never ACKed.
  - Asynchronous reset mid-transfer: lines are released immediately and the memory returns to its reset contents.
- Commit versus START: a commit and a START detected in the same clock cannot occur, because the commit is on an SCL falling edge and START requires SCL high.

Optional Feature:
- Macro: I2C_SLV_STRETCH_EN.
- Defined:
  - After each slave-ACKed byte and before each read byte, scl_o holds SCL low for STRETCH_CYCLES=16 clocks after the SCL falling edge, then releases.
  - The FSM waits for the synchronized SCL to read high before continuing.
- Undefined: scl_o is tied to 1 and no stretch logic is generated.

Decomposition:
- Package i2c_slave_pkg holds:
  - state enum i2c_slv_state_t;
  - constants STRETCH_CYCLES=16, I2C_ACK=1'b0, I2C_NACK=1'b1;
  - op enum i2c_rw_t {WRITE=0, READ=1}.
- Sub-module i2c_bus_sync: SYNC_STAGES synchronizer plus START/STOP/rise/fall event detection; outputs one-cycle event pulses.

Test Plan:
- Write to 0x22, pointer 0x05, data 0xA1,0xB2, STOP → both bytes ACKed; wr_stb_o pulses twice at addr 5/0xA1 and addr 6/0xB2; busy_o drops after STOP.
- Write 0x22, pointer 0x05; repeated START; read 3 bytes, ACK,ACK,NACK → SDA returns 0xA1,0xB2,0x07; idle after STOP.
- Write 0x22, pointer 0x3F, data 0x11,0x22 → commits at addr 63 and addr 0 (wrap); a subsequent read from 0x3F returns 0x11,0x22.
- Address 0x23 write with data → address byte NACKed; sda_o stays 1 for the whole transfer; no wr_stb_o; memory unchanged.
- Reset asserted during the 4th bit of a read byte → sda_o=1, busy_o=0 within 0 clocks (async); memory byte 5 reads back 0x05.
- With I2C_SLV_STRETCH_EN, write 0x22 → SCL held low 16 clocks after the address ACK; transfer completes correctly with iicmb at its default bus speed.

Source files
------------

// File: rtl/i2c_slave_pkg.sv
// Shared types and constants for the i2c_slave_mem register-memory slave.
package i2c_slave_pkg;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    ADDR     = 4'd1,
    ADDR_ACK = 4'd2,
    PTR      = 4'd3,
    PTR_ACK  = 4'd4,
    WR_DATA  = 4'd5,
    WR_ACK   = 4'd6,
    RD_DATA  = 4'd7,
    RD_ACK   = 4'd8
  } i2c_slv_state_t;

  typedef enum logic {
    WRITE = 1'b0,
    READ  = 1'b1
  } i2c_rw_t;

  localparam int   STRETCH_CYCLES = 16;
  localparam logic I2C_ACK        = 1'b0;
  localparam logic I2C_NACK       = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizer with START/STOP and SCL edge detection.
// Events come from the last two synchronized samples and are one-cycle pulses.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl,
  input  logic sda,
  output logic sda_sync,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic [SYNC_STAGES-1:0] scl_ff;
  logic [SYNC_STAGES-1:0] sda_ff;
  logic                   scl_cur;
  logic                   sda_cur;
  logic                   scl_prev;
  logic                   sda_prev;

  // Synchronizer chains plus one history flop per line; idle bus reads high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_ff   <= '1;
      sda_ff   <= '1;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_ff[0] <= scl;
      sda_ff[0] <= sda;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        scl_ff[i] <= scl_ff[i-1];
        sda_ff[i] <= sda_ff[i-1];
      end
      scl_prev <= scl_cur;
      sda_prev <= sda_cur;
    end
  end

  assign scl_cur  = scl_ff[SYNC_STAGES-1];
  assign sda_cur  = sda_ff[SYNC_STAGES-1];
  assign sda_sync = sda_cur;

  assign scl_rise = scl_cur & ~scl_prev;
  assign scl_fall = ~scl_cur & scl_prev;
  // SDA moving while SCL is stably high marks bus conditions.
  assign start    = scl_cur & scl_prev & sda_prev & ~sda_cur;
  assign stop     = scl_cur & scl_prev & ~sda_prev & sda_cur;

endmodule

// File: rtl/i2c_slave_mem.sv
// I2C slave with EEPROM-style pointer-addressed byte memory.
// Write: addr+W, pointer byte, data bytes (each committed on the ACK-ending
// SCL fall). Read: addr+R, bytes streamed from the pointer until master NACK.
// Optional clock stretching is enabled with macro I2C_SLV_STRETCH_EN.
module i2c_slave_mem
  import i2c_slave_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = 7'h22,
  parameter int         MEM_DEPTH   = 64,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         scl_i,
  input  logic                         sda_i,
  output logic                         scl_o,
  output logic                         sda_o,
  output logic                         busy_o,
  output logic                         wr_stb_o,
  output logic [$clog2(MEM_DEPTH)-1:0] wr_addr_o,
  output logic [7:0]                   wr_data_o,
  output logic [3:0]                   state_o
);

  localparam int            AW      = $clog2(MEM_DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic sda_sync;
  logic scl_rise;
  logic scl_fall;
  logic ev_start;
  logic ev_stop;
  logic stalled;

  i2c_slv_state_t state_q, state_d;
  logic [3:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     rx_q, rx_d;
  logic [7:0]     tx_q, tx_d;
  i2c_rw_t        rw_q, rw_d;
  logic           sda_q, sda_d;
  logic [AW-1:0]  ptr_q, ptr_d;
  logic           busy_q, busy_d;
  logic           wr_stb_q, wr_stb_d;
  logic [AW-1:0]  wr_addr_q, wr_addr_d;
  logic [7:0]     wr_data_q, wr_data_d;
  logic           mem_we;

  logic [7:0]     mem [MEM_DEPTH];
  logic [AW-1:0]  ptr_inc;
  logic [7:0]     rd_cur;
  logic [7:0]     rd_next;

  i2c_bus_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk      (clk_i),
    .rst_n    (rst_n_i),
    .scl      (scl_i),
    .sda      (sda_i),
    .sda_sync (sda_sync),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (ev_start),
    .stop     (ev_stop)
  );

  assign ptr_inc = ptr_q + PTR_ONE;
  assign rd_cur  = mem[ptr_q];
  assign rd_next = mem[ptr_inc];

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath updates; SDA only moves on a detected SCL fall.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    rw_d      = rw_q;
    sda_d     = sda_q;
    ptr_d     = ptr_q;
    busy_d    = busy_q;
    wr_stb_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    mem_we    = 1'b0;

    if (ev_start) begin
      // Repeated START aborts any partial byte; the pointer survives.
      state_d   = ADDR;
      bit_cnt_d = 4'd0;
      sda_d     = 1'b1;
    end else if (ev_stop) begin
      state_d = IDLE;
      sda_d   = 1'b1;
      busy_d  = 1'b0;
    end else if (!stalled) begin
      case (state_q)
        IDLE: begin
          sda_d = 1'b1;
        end

        ADDR: begin
          if (scl_rise) begin
            rx_d      = {rx_q[6:0], sda_sync};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            bit_cnt_d = 4'd0;
            // General call (7'h00) is never acknowledged.
            if (rx_q[7:1] == SLAVE_ADDR && rx_q[7:1] != 7'h00) begin
              state_d = ADDR_ACK;
              sda_d   = I2C_ACK;
              busy_d  = 1'b1;
              rw_d    = i2c_rw_t'(rx_q[0]);
              tx_d    = rd_cur;
            end else begin
              state_d = IDLE;
              sda_d   = 1'b1;
            end
          end
        end

        ADDR_ACK: begin
          if (scl_fall) begin
            bit_cnt_d = 4'd0;
            if (rw_q == WRITE) begin
              state_d = PTR;
              sda_d   = 1'b1;
            end else begin
              state_d = RD_DATA;
              sda_d   = tx_q[7];
              tx_d    = {tx_q[6:0], 1'b1};
            end
          end
        end

        PTR: begin
          if (scl_rise) begin
            rx_d      = {rx_q[6:0], sda_sync};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            bit_cnt_d = 4'd0;
            ptr_d     = rx_q[AW-1:0];
            state_d   = PTR_ACK;
            sda_d     = I2C_ACK;
          end
        end

        PTR_ACK: begin
          if (scl_fall) begin
            bit_cnt_d = 4'd0;
            state_d   = WR_DATA;
            sda_d     = 1'b1;
          end
        end

        WR_DATA: begin
          if (scl_rise) begin
            rx_d      = {rx_q[6:0], sda_sync};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            bit_cnt_d = 4'd0;
            state_d   = WR_ACK;
            sda_d     = I2C_ACK;
          end
        end

        WR_ACK: begin
          // Commit only once the ACK bit has fully completed.
          if (scl_fall) begin
            mem_we    = 1'b1;
            wr_stb_d  = 1'b1;
            wr_addr_d = ptr_q;
            wr_data_d = rx_q;
            ptr_d     = ptr_inc;
            bit_cnt_d = 4'd0;
            state_d   = WR_DATA;
            sda_d     = 1'b1;
          end
        end

        RD_DATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              bit_cnt_d = 4'd0;
              state_d   = RD_ACK;
              sda_d     = 1'b1;
            end else begin
              sda_d = tx_q[7];
              tx_d  = {tx_q[6:0], 1'b1};
            end
          end
        end

        RD_ACK: begin
          if (scl_rise) begin
            rx_d      = {rx_q[6:0], sda_sync};
            bit_cnt_d = 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd1) begin
            bit_cnt_d = 4'd0;
            ptr_d     = ptr_inc;
            if (rx_q[0] == I2C_NACK) begin
              state_d = IDLE;
              sda_d   = 1'b1;
            end else begin
              state_d = RD_DATA;
              sda_d   = rd_next[7];
              tx_d    = {rd_next[6:0], 1'b1};
            end
          end
        end

        default: begin
          state_d = IDLE;
          sda_d   = 1'b1;
        end
      endcase
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      bit_cnt_q <= 4'd0;
      rx_q      <= 8'h00;
      tx_q      <= 8'hFF;
      rw_q      <= WRITE;
      sda_q     <= 1'b1;
      ptr_q     <= '0;
      busy_q    <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 8'h00;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      rw_q      <= rw_d;
      sda_q     <= sda_d;
      ptr_q     <= ptr_d;
      busy_q    <= busy_d;
      wr_stb_q  <= wr_stb_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Byte memory; reset restores the identity pattern (byte i holds i).
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem[i] <= 8'(i);
      end
    end else if (mem_we) begin
      mem[ptr_q] <= rx_q;
    end
  end

`ifdef I2C_SLV_STRETCH_EN
  logic [4:0] stretch_q;
  logic       stretch_go;

  // Stretch after every slave-ACKed byte and before every read byte.
  assign stretch_go = scl_fall && !stalled && !ev_start && !ev_stop &&
                      (state_q == ADDR_ACK || state_q == PTR_ACK ||
                       state_q == WR_ACK ||
                       (state_q == RD_ACK && bit_cnt_q == 4'd1 &&
                        rx_q[0] == I2C_ACK));

  // Countdown holding SCL low; the FSM resumes on the next real SCL rise.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stretch_q <= 5'd0;
    end else if (stretch_go) begin
      stretch_q <= 5'(STRETCH_CYCLES);
    end else if (stretch_q != 5'd0) begin
      stretch_q <= stretch_q - 5'd1;
    end
  end

  assign stalled = (stretch_q != 5'd0);
  assign scl_o   = ~stalled;
`else
  assign stalled = 1'b0;
  assign scl_o   = 1'b1;
`endif

  assign sda_o     = sda_q;
  assign busy_o    = busy_q;
  assign wr_stb_o  = wr_stb_q;
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_i2c_slave_mem.sv
// Bench for i2c_slave_mem: bit-level I2C master on an open-drain bus,
// table of write/readback vectors plus hand-written multi-cycle sequences.
module tb_i2c_slave_mem;
  import i2c_slave_pkg::*;

  localparam int Q = 8;  // clocks per quarter SCL period

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       scl_bus, sda_bus;
  logic       scl_o, sda_o, busy_o, wr_stb_o;
  logic [5:0] wr_addr_o;
  logic [7:0] wr_data_o;
  logic [3:0] state_o;

  assign scl_bus = scl_m & scl_o;
  assign sda_bus = sda_m & sda_o;

  i2c_slave_mem dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .scl_i     (scl_bus),
    .sda_i     (sda_bus),
    .scl_o     (scl_o),
    .sda_o     (sda_o),
    .busy_o    (busy_o),
    .wr_stb_o  (wr_stb_o),
    .wr_addr_o (wr_addr_o),
    .wr_data_o (wr_data_o),
    .state_o   (state_o)
  );

  // ---------------- scoreboard ----------------
  int          total = 0;
  int          bad   = 0;
  logic [13:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Every commit strobe must match the next expected {addr,data}.
  always @(negedge clk) begin
    if (rst_n && wr_stb_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_commit: got addr %0h data %0h, want no commit", wr_addr_o, wr_data_o);
      end else begin
        check("commit", {18'h0, wr_addr_o, wr_data_o}, {18'h0, exp_q.pop_front()});
      end
    end
  end

  logic watch    = 1'b0;
  logic saw_low  = 1'b0;
  int   low_run  = 0;
  int   low_max  = 0;

  always @(negedge clk) begin
    if (watch && sda_o === 1'b0) saw_low = 1'b1;
    if (scl_o === 1'b0) begin
      low_run = low_run + 1;
      if (low_run > low_max) low_max = low_run;
    end else begin
      low_run = 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_scl_high();
    int n = 0;
    while (scl_bus !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (scl_bus !== 1'b1) check("scl_release_timeout", {31'h0, scl_bus}, 1);
  endtask

  task automatic m_start();
    sda_m = 1'b1; scl_m = 1'b1; wait_clk(Q);
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic m_rstart();
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_scl_high(); wait_clk(Q);
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic m_stop();
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b1; wait_scl_high(); wait_clk(Q);
    sda_m = 1'b1; wait_clk(Q);
  endtask

  task automatic m_bit(input logic b, output logic r);
    sda_m = b; wait_clk(Q);
    scl_m = 1'b1; wait_scl_high(); wait_clk(Q);
    r = sda_bus; wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic m_wbyte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) m_bit(d[i], r);
    m_bit(1'b1, ack);
  endtask

  task automatic m_rbyte(input logic nack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      m_bit(1'b1, r);
      d[i] = r;
    end
    m_bit(nack, r);
  endtask

  task automatic set_ptr(input logic [7:0] p);
    logic a;
    m_start();
    m_wbyte(8'h44, a); check("ptr_addr_ack", {31'h0, a}, 0);
    m_wbyte(p, a);     check("ptr_ack", {31'h0, a}, 0);
  endtask

  task automatic start_read();
    logic a;
    m_rstart();
    m_wbyte(8'h45, a); check("rd_addr_ack", {31'h0, a}, 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [6:0] addr;
    logic [7:0] ptr;
    logic [7:0] wdata;
    logic       exp_ack;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic       a;
    logic       r;
    logic [7:0] d;

    vecs[0] = '{addr: 7'h22, ptr: 8'h10, wdata: 8'h5A, exp_ack: 1'b0, exp_rd: 8'h5A};
    vecs[1] = '{addr: 7'h23, ptr: 8'h10, wdata: 8'hFF, exp_ack: 1'b1, exp_rd: 8'h5A};
    vecs[2] = '{addr: 7'h00, ptr: 8'h11, wdata: 8'hEE, exp_ack: 1'b1, exp_rd: 8'h11};
    vecs[3] = '{addr: 7'h22, ptr: 8'h47, wdata: 8'h3C, exp_ack: 1'b0, exp_rd: 8'h3C};
    vecs[4] = '{addr: 7'h22, ptr: 8'h20, wdata: 8'h00, exp_ack: 1'b0, exp_rd: 8'h00};
    vecs[5] = '{addr: 7'h11, ptr: 8'h21, wdata: 8'h77, exp_ack: 1'b1, exp_rd: 8'h21};

    // Reset values
    wait_clk(3);
    check("rst_scl_o", {31'h0, scl_o}, 1);
    check("rst_sda_o", {31'h0, sda_o}, 1);
    check("rst_busy", {31'h0, busy_o}, 0);
    check("rst_wr_stb", {31'h0, wr_stb_o}, 0);
    check("rst_wr_addr", {26'h0, wr_addr_o}, 0);
    check("rst_wr_data", {24'h0, wr_data_o}, 0);
    check("rst_state", {28'h0, state_o}, IDLE);
    rst_n = 1'b1;
    wait_clk(4);

    // Two-byte write at pointer 5
    exp_q.push_back({6'h05, 8'hA1});
    exp_q.push_back({6'h06, 8'hB2});
    m_start();
    m_wbyte(8'h44, a); check("t1_addr_ack", {31'h0, a}, 0);
    check("t1_busy", {31'h0, busy_o}, 1);
    m_wbyte(8'h05, a); check("t1_ptr_ack", {31'h0, a}, 0);
    m_wbyte(8'hA1, a); check("t1_d0_ack", {31'h0, a}, 0);
    m_wbyte(8'hB2, a); check("t1_d1_ack", {31'h0, a}, 0);
    m_stop();
    wait_clk(2);
    check("t1_busy_after_stop", {31'h0, busy_o}, 0);
    check("t1_commits_seen", exp_q.size(), 0);

    // Pointer write, repeated START, 3-byte read ending in NACK
    set_ptr(8'h05);
    start_read();
    m_rbyte(1'b0, d); check("t2_rd0", {24'h0, d}, 8'hA1);
    m_rbyte(1'b0, d); check("t2_rd1", {24'h0, d}, 8'hB2);
    m_rbyte(1'b1, d); check("t2_rd2", {24'h0, d}, 8'h07);
    check("t2_sda_released", {31'h0, sda_o}, 1);
    m_stop();
    wait_clk(2);
    check("t2_idle", {28'h0, state_o}, IDLE);
    check("t2_busy", {31'h0, busy_o}, 0);

    // Pointer wrap 63 -> 0 on write and read
    exp_q.push_back({6'h3F, 8'h11});
    exp_q.push_back({6'h00, 8'h22});
    m_start();
    m_wbyte(8'h44, a); check("t3_addr_ack", {31'h0, a}, 0);
    m_wbyte(8'h3F, a); check("t3_ptr_ack", {31'h0, a}, 0);
    m_wbyte(8'h11, a); check("t3_d0_ack", {31'h0, a}, 0);
    m_wbyte(8'h22, a); check("t3_d1_ack", {31'h0, a}, 0);
    m_stop();
    set_ptr(8'h3F);
    start_read();
    m_rbyte(1'b0, d); check("t3_rd63", {24'h0, d}, 8'h11);
    m_rbyte(1'b1, d); check("t3_rd0", {24'h0, d}, 8'h22);
    m_stop();

    // Table: write with given address, then read back from the pointer
    for (int v = 0; v < 6; v++) begin
      if (vecs[v].exp_ack == 1'b0) exp_q.push_back({vecs[v].ptr[5:0], vecs[v].wdata});
      saw_low = 1'b0;
      watch   = 1'b1;
      m_start();
      m_wbyte({vecs[v].addr, 1'b0}, a); check("vec_addr_ack", {31'h0, a}, {31'h0, vecs[v].exp_ack});
      m_wbyte(vecs[v].ptr, a);          check("vec_ptr_ack", {31'h0, a}, {31'h0, vecs[v].exp_ack});
      m_wbyte(vecs[v].wdata, a);        check("vec_data_ack", {31'h0, a}, {31'h0, vecs[v].exp_ack});
      m_stop();
      watch = 1'b0;
      check("vec_sda_drive", {31'h0, saw_low}, {31'h0, ~vecs[v].exp_ack});
      set_ptr(vecs[v].ptr);
      start_read();
      m_rbyte(1'b1, d);
      m_stop();
      check("vec_readback", {24'h0, d}, {24'h0, vecs[v].exp_rd});
    end
    check("all_commits_seen", exp_q.size(), 0);

    // Asynchronous reset during the 4th bit of a read byte (0xA1, bit4 = 0)
    set_ptr(8'h05);
    start_read();
    for (int i = 0; i < 3; i++) m_bit(1'b1, r);
    sda_m = 1'b1;
    wait_clk(Q);
    check("t5_bit4_driven", {31'h0, sda_o}, 0);
    check("t5_busy_before", {31'h0, busy_o}, 1);
    scl_m = 1'b1;
    wait_clk(Q);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_sda_async", {31'h0, sda_o}, 1);
    check("t5_busy_async", {31'h0, busy_o}, 0);
    scl_m = 1'b1;
    sda_m = 1'b1;
    wait_clk(4);
    rst_n = 1'b1;
    wait_clk(4);
    check("t5_state_idle", {28'h0, state_o}, IDLE);
    set_ptr(8'h05);
    start_read();
    m_rbyte(1'b1, d);
    m_stop();
    check("t5_mem5_reset", {24'h0, d}, 8'h05);

`ifdef I2C_SLV_STRETCH_EN
    check("stretch_len", low_max, 16);
`else
    check("no_stretch", low_max, 0);
`endif

    wait_clk(4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
